oled_frame_sequencer: RTL and testbench



---
 rtl/oled_frame_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_oled_frame_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_frame_sequencer.sv
// -----------------------------------------------------------------------------
// oled_frame_sequencer
//
// Drives the SPI byte sender for an SSD1331 96x64 OLED. After reset it runs
// the panel reset pulse (optional) and the 8-byte init command list. On each
// frame request it sends the 6-byte address-window command list, then streams
// PIX_BYTES pixel bytes popped from the frame source.
//
// Optional feature macro: OLED_FRAME_SEQ_RST_SEQ_EN
//   defined   : o_oled_rst_n is held low for RST_CYCLES cycles, then high for
//               RST_CYCLES cycles before the init list starts.
//   undefined : o_oled_rst_n stays 1; the reset states last one cycle each.
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous, active-high reset
//   i_start          frame request (level-sampled)
//   i_pix_data       next pixel byte from the frame source
//   o_pix_req        one-cycle pop; i_pix_data is consumed on the ending edge
//   o_spi_data       byte presented to the sender
//   o_spi_data_ready sender enable, high for exactly one byte
//   i_spi_done       sender done (asynchronous, synchronized internally)
//   o_dc             panel D/C: 0 = command, 1 = pixel data
//   o_oled_rst_n     panel reset, active-low
//   o_busy           high until ready for a frame, and during a frame
//   o_frame_done     one-cycle pulse after the last pixel byte's gap
// -----------------------------------------------------------------------------
module oled_frame_sequencer #(
    parameter int PIX_BYTES  = 12288,
    parameter int GAP_CYCLES = 4,
    parameter int RST_CYCLES = 1200000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_pix_data,
    output logic       o_pix_req,
    output logic [7:0] o_spi_data,
    output logic       o_spi_data_ready,
    input  logic       i_spi_done,
    output logic       o_dc,
    output logic       o_oled_rst_n,
    output logic       o_busy,
    output logic       o_frame_done
);

    // The shared index must also cover the 8-entry init list.
    localparam int PIX_W = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam int IDX_W = (PIX_W > 3) ? PIX_W : 3;
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W = (RST_W > GAP_W) ? RST_W : GAP_W;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_LOAD     = 3'd3,
        ST_SEND     = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT = 2'd0,
        PH_WIN  = 2'd1,
        PH_PIX  = 2'd2
    } phase_t;

    state_t             state_r;
    phase_t             phase_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               pend_r;
    logic               seen_low_r;
    logic               done_meta_r;
    logic               done_s;

    logic [7:0]         byte_s;
    logic               dc_s;
    logic [IDX_W-1:0]   last_idx_s;
    logic               pend_arm_s;
    logic               gap_end_s;
    logic               idx_last_s;

    // Panel power-up command list.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = 8'hAE;
            3'd1:    init_rom = 8'hA0;
            3'd2:    init_rom = 8'h72;
            3'd3:    init_rom = 8'hA1;
            3'd4:    init_rom = 8'h00;
            3'd5:    init_rom = 8'hA2;
            3'd6:    init_rom = 8'h00;
            3'd7:    init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction

    // Full-screen column/row address window.
    function automatic logic [7:0] win_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    win_rom = 8'h15;
            3'd1:    win_rom = 8'h00;
            3'd2:    win_rom = 8'h5F;
            3'd3:    win_rom = 8'h75;
            3'd4:    win_rom = 8'h00;
            3'd5:    win_rom = 8'h3F;
            default: win_rom = 8'h00;
        endcase
    endfunction

    // Two-flop synchronizer for the sender's done flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_meta_r <= 1'b0;
            done_s      <= 1'b0;
        end else begin
            done_meta_r <= i_spi_done;
            done_s      <= done_meta_r;
        end
    end

    // Byte source, D/C value and last index for the current phase.
    always_comb begin
        byte_s     = 8'h00;
        dc_s       = 1'b0;
        last_idx_s = '0;
        case (phase_r)
            PH_INIT: begin
                byte_s     = init_rom(idx_r[2:0]);
                last_idx_s = IDX_W'(7);
            end
            PH_WIN: begin
                byte_s     = win_rom(idx_r[2:0]);
                last_idx_s = IDX_W'(5);
            end
            PH_PIX: begin
                byte_s     = i_pix_data;
                dc_s       = 1'b1;
                last_idx_s = IDX_W'(PIX_BYTES - 1);
            end
            default: begin
                byte_s     = 8'h00;
                dc_s       = 1'b0;
                last_idx_s = '0;
            end
        endcase
    end

    // A request during reset or init is remembered; one during a frame is not.
    always_comb begin
        pend_arm_s = 1'b0;
        if (state_r == ST_RST_HOLD || state_r == ST_RST_WAIT) begin
            pend_arm_s = i_start;
        end else if (phase_r == PH_INIT && state_r != ST_IDLE) begin
            pend_arm_s = i_start;
        end else begin
            pend_arm_s = 1'b0;
        end
        gap_end_s  = (cnt_r == CNT_W'(GAP_CYCLES - 1));
        idx_last_s = (idx_r == last_idx_s);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r          <= ST_RST_HOLD;
            phase_r          <= PH_INIT;
            idx_r            <= '0;
            cnt_r            <= '0;
            pend_r           <= 1'b0;
            seen_low_r       <= 1'b0;
            o_spi_data       <= 8'h00;
            o_spi_data_ready <= 1'b0;
            o_dc             <= 1'b0;
            o_pix_req        <= 1'b0;
            o_frame_done     <= 1'b0;
            o_busy           <= 1'b1;
`ifdef OLED_FRAME_SEQ_RST_SEQ_EN
            o_oled_rst_n     <= 1'b0;
`else
            o_oled_rst_n     <= 1'b1;
`endif
        end else begin
            o_pix_req    <= 1'b0;
            o_frame_done <= 1'b0;
            if (pend_arm_s) begin
                pend_r <= 1'b1;
            end
            case (state_r)
                ST_RST_HOLD: begin
`ifdef OLED_FRAME_SEQ_RST_SEQ_EN
                    if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
                        cnt_r        <= '0;
                        o_oled_rst_n <= 1'b1;
                        state_r      <= ST_RST_WAIT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
`else
                    state_r <= ST_RST_WAIT;
`endif
                end
                ST_RST_WAIT: begin
`ifdef OLED_FRAME_SEQ_RST_SEQ_EN
                    if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
                        cnt_r   <= '0;
                        phase_r <= PH_INIT;
                        idx_r   <= '0;
                        state_r <= ST_LOAD;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
`else
                    phase_r <= PH_INIT;
                    idx_r   <= '0;
                    state_r <= ST_LOAD;
`endif
                end
                ST_IDLE: begin
                    if (i_start || pend_r) begin
                        phase_r <= PH_WIN;
                        idx_r   <= '0;
                        pend_r  <= 1'b0;
                        o_busy  <= 1'b1;
                        state_r <= ST_LOAD;
                    end else begin
                        // Falls here one cycle after entry, so o_frame_done
                        // always leads the busy drop by one cycle.
                        o_busy <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    o_spi_data <= byte_s;
                    o_dc       <= dc_s;
                    seen_low_r <= 1'b0;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    // Ready rises one cycle after data/dc settle. A done flag
                    // left high from the previous byte is ignored until it
                    // has been seen low.
                    if (!done_s) begin
                        seen_low_r <= 1'b1;
                    end
                    if (seen_low_r && done_s) begin
                        o_spi_data_ready <= 1'b0;
                        cnt_r            <= '0;
                        state_r          <= ST_GAP;
                    end else begin
                        o_spi_data_ready <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (!gap_end_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else if (!idx_last_s) begin
                        idx_r     <= idx_r + IDX_W'(1);
                        o_pix_req <= (phase_r == PH_PIX);
                        state_r   <= ST_LOAD;
                    end else begin
                        case (phase_r)
                            PH_INIT: begin
                                state_r <= ST_IDLE;
                            end
                            PH_WIN: begin
                                phase_r   <= PH_PIX;
                                idx_r     <= '0;
                                o_pix_req <= 1'b1;
                                state_r   <= ST_LOAD;
                            end
                            PH_PIX: begin
                                o_frame_done <= 1'b1;
                                state_r      <= ST_IDLE;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= ST_RST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
module tb_oled_frame_sequencer;

    localparam int PIX_BYTES  = 4;
    localparam int GAP_CYCLES = 2;
    localparam int RST_CYCLES = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pix_data;
    logic       pix_req;
    logic [7:0] spi_data;
    logic       spi_ready;
    logic       spi_done;
    logic       dc;
    logic       oled_rst_n;
    logic       busy;
    logic       frame_done;

    oled_frame_sequencer #(
        .PIX_BYTES (PIX_BYTES),
        .GAP_CYCLES(GAP_CYCLES),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_pix_data      (pix_data),
        .o_pix_req       (pix_req),
        .o_spi_data      (spi_data),
        .o_spi_data_ready(spi_ready),
        .i_spi_done      (spi_done),
        .o_dc            (dc),
        .o_oled_rst_n    (oled_rst_n),
        .o_busy          (busy),
        .o_frame_done    (frame_done)
    );

    int         checks;
    int         errors;
    logic [8:0] exp_q[$];
    int         clr_delay;
    int         pix_ptr;
    logic       pop_flag;
    logic [7:0] pix_mem [0:7];
    int         byte_cnt;
    int         pix_req_cnt;
    int         frame_done_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected {dc, byte} pairs.
    task automatic push_init();
        exp_q.push_back({1'b0, 8'hAE}); exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b0, 8'h72}); exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'hA2});
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'hAF});
    endtask

    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h15}); exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h5F}); exp_q.push_back({1'b0, 8'h75});
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'h3F});
        exp_q.push_back({1'b1, 8'h11}); exp_q.push_back({1'b1, 8'h22});
        exp_q.push_back({1'b1, 8'h33}); exp_q.push_back({1'b1, 8'h44});
    endtask

    task automatic clear_counts();
        byte_cnt       = 0;
        pix_req_cnt    = 0;
        frame_done_cnt = 0;
    endtask

    task automatic wait_busy_low(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic wait_bytes(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (byte_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (byte_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, byte_cnt, target);
        end
    endtask

    task automatic start_frame();
        pix_ptr = 0;
        clear_counts();
        push_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_frame_end(input string name, input int bytes, input int frames);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_byte_count"}, byte_cnt, bytes);
        chk({name, "_pix_req_count"}, pix_req_cnt, 4 * frames);
        chk({name, "_frame_done_count"}, frame_done_cnt, frames);
    endtask

    // Frame source: advances one entry after each popped byte.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_flag) begin
                pix_ptr++;
                pop_flag = 1'b0;
            end
            pix_data = pix_mem[pix_ptr % 8];
        end
    end

    // Sender model: done rises 20 cycles after ready rises, clears
    // clr_delay cycles after ready falls.
    initial begin
        int  up_cnt;
        int  dn_cnt;
        logic rdy_prev;
        up_cnt = 0; dn_cnt = 0; rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                up_cnt = 0; dn_cnt = 0; spi_done = 1'b0;
            end else begin
                if (spi_ready && !rdy_prev) up_cnt = 20;
                if (!spi_ready && rdy_prev) dn_cnt = clr_delay;
                if (up_cnt > 0) begin
                    up_cnt--;
                    if (up_cnt == 0) spi_done = 1'b1;
                end
                if (dn_cnt > 0) begin
                    dn_cnt--;
                    if (dn_cnt == 0) spi_done = 1'b0;
                end
            end
            rdy_prev = spi_ready;
        end
    end

    // Monitor: pops the scoreboard on each ready rise and checks timing.
    initial begin
        logic       rdy_q;
        logic [8:0] prev_word;
        logic [8:0] cap_word;
        logic [8:0] e;
        logic       done_q;
        rdy_q = 1'b0; prev_word = 9'h000; cap_word = 9'h000; done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (spi_ready && !rdy_q) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte actual=%0h required=none", {dc, spi_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", byte_cnt), {dc, spi_data}, e);
                        chk("setup_before_ready", prev_word, {dc, spi_data});
                    end
                    byte_cnt++;
                    cap_word = {dc, spi_data};
                end
                if (!spi_ready && rdy_q) begin
                    chk("hold_until_fall", {dc, spi_data}, cap_word);
                end
                if (pix_req) begin
                    pix_req_cnt++;
                    pop_flag = 1'b1;
                end
                if (done_q) begin
                    chk("busy_after_done", busy, 1'b0);
                    done_q = 1'b0;
                end
                if (frame_done) begin
                    frame_done_cnt++;
                    chk("busy_at_done", busy, 1'b1);
                    done_q = 1'b1;
                end
            end
            rdy_q     = spi_ready;
            prev_word = {dc, spi_data};
        end
    end

    initial begin
        int n;
        checks = 0; errors = 0; clr_delay = 3; pix_ptr = 0; pop_flag = 1'b0;
        pix_mem[0] = 8'h11; pix_mem[1] = 8'h22; pix_mem[2] = 8'h33; pix_mem[3] = 8'h44;
        pix_mem[4] = 8'h55; pix_mem[5] = 8'h66; pix_mem[6] = 8'h77; pix_mem[7] = 8'h88;
        pix_data = 8'h11; spi_done = 1'b0; start = 1'b0; rst = 1'b1;
        clear_counts();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_spi_data", spi_data, 8'h00);
        chk("rst_ready", spi_ready, 1'b0);
        chk("rst_dc", dc, 1'b0);
        chk("rst_pix_req", pix_req, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b1);
`ifdef OLED_FRAME_SEQ_RST_SEQ_EN
        chk("rst_oled_rst_n", oled_rst_n, 1'b0);
`else
        chk("rst_oled_rst_n", oled_rst_n, 1'b1);
`endif

        // Power-up and init list
        push_init();
        rst = 1'b0;
`ifdef OLED_FRAME_SEQ_RST_SEQ_EN
        n = 0;
        while (oled_rst_n == 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("panel_rst_low_cycles", n, RST_CYCLES);
`else
        @(negedge clk);
        chk("panel_rst_tied_high", oled_rst_n, 1'b1);
`endif
        wait_busy_low(3000, "init");
        chk("init_queue_empty", exp_q.size(), 0);
        chk("init_byte_count", byte_cnt, 8);

        // Plain frame
        start_frame();
        wait_busy_low(3000, "frame1");
        check_frame_end("frame1", 10, 1);

        // Start pulse mid-frame is ignored
        start_frame();
        wait_bytes(3, 1000, "mid_start");
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_busy_low(3000, "frame2");
        repeat (200) @(negedge clk);
        check_frame_end("frame2", 10, 1);
        chk("frame2_idle_busy", busy, 1'b0);

        // Sender clears done late, past the gap
        clr_delay = 10;
        start_frame();
        wait_busy_low(5000, "frame3");
        check_frame_end("frame3", 10, 1);
        clr_delay = 3;

        // Start held through reset and init: exactly one frame follows
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        exp_q.delete();
        clear_counts();
        pix_ptr = 0;
        push_init();
        push_frame();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (exp_q.size() > 9 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("held_start_reached_window", (exp_q.size() <= 9), 1'b1);
        start = 1'b0;
        wait_busy_low(5000, "frame4");
        repeat (200) @(negedge clk);
        check_frame_end("frame4", 18, 1);

        // Reset during pixel byte 2 restarts the whole sequence
        start_frame();
        wait_bytes(8, 3000, "pix2");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ready_drop", spi_ready, 1'b0);
        chk("async_busy", busy, 1'b1);
        exp_q.delete();
        clear_counts();
        push_init();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_busy_low(3000, "reinit");
        chk("reinit_queue_empty", exp_q.size(), 0);
        chk("reinit_byte_count", byte_cnt, 8);
        chk("reinit_no_frame_done", frame_done_cnt, 0);

        // Normal frame after the restart
        start_frame();
        wait_busy_low(3000, "frame5");
        check_frame_end("frame5", 10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
